xrbus_timing_align: RTL and testbench
=====================================

# xrbus_timing_align

Parametrised XR-BUS timing-contract aligner for NUM_SRC timestamp sources. It collects one timestamp per source per epoch and computes signed deltas against a selectable reference source. It flags per-source jitter and windowed average drift, and produces a monotonic, extrapolated aligned time. It sits between the per-domain timestamp synchronisers and XR-BUS event ordering logic. It replaces the fixed three-clock aligner.

## Interface
- NUM_SRC, 4: number of timestamp sources (2..16)
- TS_W, 64: timestamp width
- WIN_W, 32: jitter_window / drift_limit width
- AVG_LOG2, 2: drift averaged over 2^AVG_LOG2 epochs
- TIMEOUT, 1024: max COLLECT cycles per epoch
- TICK_INC, 1: aligned_time increment per clk between epochs
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ts_valid  in  NUM_SRC  per-source sample strobe (synchronised to clk upstream)
- ts  in  NUM_SRC*TS_W  packed timestamps; source i at [i*TS_W +: TS_W]
- ref_sel  in  $clog2(NUM_SRC)  reference source index
- jitter_window  in  WIN_W  unsigned max |delta change| between epochs
- drift_limit  in  WIN_W  unsigned max |average delta|
- clear_flags  in  1  clears all sticky flags
- aligned_time  out  TS_W  monotonic aligned time
- time_valid  out  1  aligned_time meaningful
- epoch_done  out  1  one-cycle pulse per completed epoch
- src_stale  out  NUM_SRC  source missing in last epoch
- jitter_exceeded  out  NUM_SRC  sticky per-source jitter flag
- drift_warning  out  NUM_SRC  sticky per-source drift flag
- causality_err  out  1  sticky: reference timestamp went backwards

## Operation
- FSM states: IDLE, COLLECT, COMPUTE, UPDATE. Reset state: IDLE. IDLE→COLLECT on the first clk after reset; UPDATE→COLLECT unconditionally.
- On IDLE→COLLECT and UPDATE→COLLECT, ref_sel is latched as ref_q. Changes to ref_sel during an epoch are ignored.
- COLLECT: on ts_valid[i], capture ts[i] if source i is not yet captured this epoch. Later strobes from the same source are ignored.
- COLLECT→COMPUTE when all sources are captured, or when the cycle counter reaches TIMEOUT-1. Sources not captured get src_stale[i]=1.
- COMPUTE: delta_i = ts_i − ts_ref_q, computed modulo 2^TS_W and interpreted as signed TS_W. delta for ref_q is 0.
- UPDATE, per non-stale, non-ref source:
  - Jitter: if a previous delta is valid and |delta_i − prev_delta_i| > jitter_window, set jitter_exceeded[i]. Store prev_delta_i and mark it valid.
  - Drift: add delta_i to sum_i (signed, TS_W+AVG_LOG2 bits) and increment cnt_i. When cnt_i reaches 2^AVG_LOG2, compute avg = sum_i >>> AVG_LOG2. If |avg| > drift_limit, set drift_warning[i]. Then clear sum_i and cnt_i.
- Stale source: prev-delta valid bit cleared; sum_i and cnt_i held.
- Reference stale: the epoch updates nothing except src_stale. time_valid is unchanged and epoch_done still pulses.
- aligned_time with a valid reference:
  - If ts_ref > aligned_time (unsigned) or time_valid==0: load ts_ref and set time_valid.
  - Otherwise hold aligned_time. If ts_ref < aligned_time, also set causality_err.
- Outside UPDATE, when time_valid==1, aligned_time += TICK_INC, wrapping modulo 2^TS_W.
- Sticky flags clear on clear_flags. A set in the same cycle wins over the clear.
- Reset, including mid-epoch: all outputs 0, FSM to IDLE, all captures, sums, counters and prev-valid bits cleared.

## Timing
- Reset values: aligned_time=0, time_valid=0, epoch_done=0, src_stale=0, jitter_exceeded=0, drift_warning=0, causality_err=0.
- Capture takes effect the cycle after ts_valid.
- COMPUTE is 1 cycle and UPDATE is 1 cycle. All outputs are registered and change on the clk edge leaving UPDATE. epoch_done is high for exactly that one cycle.
- Latency from the last-arriving strobe to epoch_done is 3 clk.
- ts_valid during COMPUTE or UPDATE is dropped.
- Epoch period is at least 3 clk (all strobes already present).

## Test plan
- NUM_SRC=4, ref_sel=0. Strobe ts={1000,1005,990,1000} together. → epoch_done 3 cycles later; aligned_time=1000, time_valid=1, no flags. aligned_time then increments by 1 per cycle.
- Repeat with source 1 delta going from 5 to 40, jitter_window=20. → jitter_exceeded[1]=1 after the second epoch; other flags stay 0.
- Source 2 delta of −600 for 4 epochs, drift_limit=500, AVG_LOG2=2. → drift_warning[2] sets at the 4th epoch_done, not before.
- Source 3 silent, TIMEOUT=16. → src_stale[3]=1 and epoch_done 18 cycles after COLLECT entry. The next epoch with source 3 present does no jitter check for it.
- Reference timestamp 500 after aligned_time reaches 1010. → aligned_time keeps incrementing and causality_err=1. clear_flags then clears it.
- Assert rst_n low mid-COLLECT with two sources captured. → all outputs 0. The next epoch requires fresh strobes from all sources.

Source files
------------

// File: rtl/xrbus_timing_align.sv
// XR-BUS timing-contract aligner: gathers one timestamp per source per epoch,
// derives deltas against a latched reference, tracks jitter/drift and a monotonic aligned time.

module xrbus_ta_lane #(
  parameter int TS_W     = 64,
  parameter int WIN_W    = 32,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   stale,
  input  logic                   clear_flags,
  input  logic signed [TS_W-1:0] delta,
  input  logic [WIN_W-1:0]       jitter_window,
  input  logic [WIN_W-1:0]       drift_limit,
  output logic                   jitter_flag,
  output logic                   drift_flag
);
  localparam int DW  = TS_W + 1;
  localparam int SW  = TS_W + AVG_LOG2;
  localparam int CNW = AVG_LOG2 + 1;

  logic signed [TS_W-1:0] prev;
  logic                   prev_vld;
  logic signed [SW-1:0]   sum, sum_nx, avg;
  logic [CNW-1:0]         cnt, cnt_nx;
  logic signed [DW-1:0]   diff;
  logic [DW-1:0]          diff_mag;
  logic [SW-1:0]          avg_mag;
  logic                   avg_done, jit_set, drift_set;

  // One extra bit on the difference so opposite-signed deltas cannot overflow.
  always_comb begin
    diff      = DW'(delta) - DW'(prev);
    diff_mag  = diff[DW-1] ? DW'(-diff) : DW'(diff);
    sum_nx    = sum + SW'(delta);
    cnt_nx    = cnt + CNW'(1);
    avg_done  = (cnt_nx == CNW'(1 << AVG_LOG2));
    avg       = sum_nx >>> AVG_LOG2;
    avg_mag   = avg[SW-1] ? SW'(-avg) : SW'(avg);
    jit_set   = en && prev_vld && (diff_mag > DW'(jitter_window));
    drift_set = en && avg_done && (avg_mag > SW'(drift_limit));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= '0;
      prev_vld    <= 1'b0;
      sum         <= '0;
      cnt         <= '0;
      jitter_flag <= 1'b0;
      drift_flag  <= 1'b0;
    end else begin
      if (en) begin
        prev     <= delta;
        prev_vld <= 1'b1;
        if (avg_done) begin
          sum <= '0;
          cnt <= '0;
        end else begin
          sum <= sum_nx;
          cnt <= cnt_nx;
        end
      end else if (stale) begin
        prev_vld <= 1'b0;
      end
      jitter_flag <= (jitter_flag & ~clear_flags) | jit_set;
      drift_flag  <= (drift_flag & ~clear_flags) | drift_set;
    end
  end
endmodule

module xrbus_timing_align #(
  parameter int NUM_SRC  = 4,
  parameter int TS_W     = 64,
  parameter int WIN_W    = 32,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024,
  parameter int TICK_INC = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          ts_valid,
  input  logic [NUM_SRC*TS_W-1:0]     ts,
  input  logic [$clog2(NUM_SRC)-1:0]  ref_sel,
  input  logic [WIN_W-1:0]            jitter_window,
  input  logic [WIN_W-1:0]            drift_limit,
  input  logic                        clear_flags,
  output logic [TS_W-1:0]             aligned_time,
  output logic                        time_valid,
  output logic                        epoch_done,
  output logic [NUM_SRC-1:0]          src_stale,
  output logic [NUM_SRC-1:0]          jitter_exceeded,
  output logic [NUM_SRC-1:0]          drift_warning,
  output logic                        causality_err
);
  localparam int RW = $clog2(NUM_SRC);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, UPDATE} state_t;

  state_t                         state, state_nx;
  logic [RW-1:0]                  ref_q;
  logic [NUM_SRC-1:0]             cap, cap_nx;
  logic [NUM_SRC-1:0][TS_W-1:0]   ts_q, delta_q;
  logic [TW-1:0]                  tcnt;
  logic [TS_W-1:0]                ts_ref;
  logic                           ref_ok, upd, caus_set;

  // Captures are frozen outside COLLECT, so the reference can be read straight from ts_q.
  assign cap_nx   = cap | ts_valid;
  assign ts_ref   = ts_q[ref_q];
  assign ref_ok   = cap[ref_q];
  assign upd      = (state == UPDATE) && ref_ok;
  assign caus_set = upd && time_valid && (ts_ref < aligned_time);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = COLLECT;
      COLLECT: if ((&cap_nx) || (tcnt == TW'(TIMEOUT - 1))) state_nx = COMPUTE;
      COMPUTE: state_nx = UPDATE;
      UPDATE:  state_nx = COLLECT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q   <= '0;
      cap     <= '0;
      ts_q    <= '0;
      delta_q <= '0;
      tcnt    <= '0;
    end else begin
      case (state)
        IDLE, UPDATE: begin
          ref_q <= ref_sel;
          cap   <= '0;
          tcnt  <= '0;
        end
        COLLECT: begin
          cap  <= cap_nx;
          tcnt <= tcnt + TW'(1);
          for (int i = 0; i < NUM_SRC; i++)
            if (ts_valid[i] && !cap[i]) ts_q[i] <= ts[i*TS_W +: TS_W];
        end
        COMPUTE: begin
          for (int i = 0; i < NUM_SRC; i++) delta_q[i] <= ts_q[i] - ts_ref;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aligned_time  <= '0;
      time_valid    <= 1'b0;
      epoch_done    <= 1'b0;
      src_stale     <= '0;
      causality_err <= 1'b0;
    end else begin
      epoch_done <= (state == UPDATE);
      if (state == UPDATE) src_stale <= ~cap;
      if (upd) begin
        if (!time_valid || (ts_ref > aligned_time)) begin
          aligned_time <= ts_ref;
          time_valid   <= 1'b1;
        end
      end else if ((state != UPDATE) && time_valid) begin
        aligned_time <= aligned_time + TS_W'(TICK_INC);
      end
      causality_err <= (causality_err & ~clear_flags) | caus_set;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    xrbus_ta_lane #(.TS_W(TS_W), .WIN_W(WIN_W), .AVG_LOG2(AVG_LOG2)) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (upd && cap[g] && (ref_q != RW'(g))),
      .stale        (upd && !cap[g]),
      .clear_flags  (clear_flags),
      .delta        (delta_q[g]),
      .jitter_window(jitter_window),
      .drift_limit  (drift_limit),
      .jitter_flag  (jitter_exceeded[g]),
      .drift_flag   (drift_warning[g])
    );
  end
endmodule

// File: tb/tb_xrbus_timing_align.sv
// Directed bench for xrbus_timing_align: table of epochs plus hand sequences for
// monotonic increment, causality/clear and mid-epoch reset.

module tb_xrbus_timing_align;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ts_valid;
  logic [255:0] ts;
  logic [1:0]   ref_sel;
  logic [31:0]  jitter_window, drift_limit;
  logic         clear_flags;
  logic [63:0]  aligned_time;
  logic         time_valid, epoch_done, causality_err;
  logic [3:0]   src_stale, jitter_exceeded, drift_warning;

  int checks = 0;
  int errors = 0;

  xrbus_timing_align #(.NUM_SRC(4), .TS_W(64), .WIN_W(32), .AVG_LOG2(2),
                       .TIMEOUT(16), .TICK_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .ts_valid(ts_valid), .ts(ts), .ref_sel(ref_sel),
    .jitter_window(jitter_window), .drift_limit(drift_limit), .clear_flags(clear_flags),
    .aligned_time(aligned_time), .time_valid(time_valid), .epoch_done(epoch_done),
    .src_stale(src_stale), .jitter_exceeded(jitter_exceeded), .drift_warning(drift_warning),
    .causality_err(causality_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  m;
    logic [63:0] t0, t1, t2, t3;
    int          lat;
    logic [63:0] at;
    logic [3:0]  stale, jit, drift;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Strobe one epoch, then count negedges until epoch_done (bounded).
  task automatic epoch(input logic [3:0] m, input logic [63:0] t0, t1, t2, t3, output int lat);
    @(negedge clk);
    ts_valid = m;
    ts = {t3, t2, t1, t0};
    @(negedge clk);
    ts_valid = '0;
    lat = 1;
    while (!epoch_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vt[11];

  initial begin
    int lat, n;
    logic [63:0] a0;
    logic seen;
    rst_n = 1'b0; ts_valid = '0; ts = '0; ref_sel = 2'd0;
    jitter_window = 32'd20; drift_limit = 32'd500; clear_flags = 1'b0;

    vt[0]  = '{1'b1, 4'hF, 64'd1000, 64'd1005, 64'd990,  64'd1000, 3,  64'd1000, 4'h0, 4'h0, 4'h0};
    vt[1]  = '{1'b0, 4'hF, 64'd2000, 64'd2040, 64'd1990, 64'd2000, 3,  64'd2000, 4'h0, 4'h2, 4'h0};
    vt[2]  = '{1'b0, 4'hF, 64'd3000, 64'd3040, 64'd2990, 64'd3000, 3,  64'd3000, 4'h0, 4'h2, 4'h0};
    vt[3]  = '{1'b0, 4'hF, 64'd4000, 64'd4040, 64'd3990, 64'd4000, 3,  64'd4000, 4'h0, 4'h2, 4'h0};
    vt[4]  = '{1'b1, 4'hF, 64'd1000, 64'd1000, 64'd400,  64'd1000, 3,  64'd1000, 4'h0, 4'h0, 4'h0};
    vt[5]  = '{1'b0, 4'hF, 64'd2000, 64'd2000, 64'd1400, 64'd2000, 3,  64'd2000, 4'h0, 4'h0, 4'h0};
    vt[6]  = '{1'b0, 4'hF, 64'd3000, 64'd3000, 64'd2400, 64'd3000, 3,  64'd3000, 4'h0, 4'h0, 4'h0};
    vt[7]  = '{1'b0, 4'hF, 64'd4000, 64'd4000, 64'd3400, 64'd4000, 3,  64'd4000, 4'h0, 4'h0, 4'h4};
    vt[8]  = '{1'b1, 4'hF, 64'd1000, 64'd1000, 64'd1000, 64'd1000, 3,  64'd1000, 4'h0, 4'h0, 4'h0};
    vt[9]  = '{1'b0, 4'h7, 64'd2000, 64'd2000, 64'd2000, 64'd0,    17, 64'd2000, 4'h8, 4'h0, 4'h0};
    vt[10] = '{1'b0, 4'hF, 64'd3000, 64'd3000, 64'd3000, 64'd3100, 3,  64'd3000, 4'h0, 4'h0, 4'h0};

    repeat (3) @(negedge clk);
    chk("rst_aligned", aligned_time, 64'd0);
    chk("rst_valid", {63'd0, time_valid}, 64'd0);
    chk("rst_flags", {48'd0, src_stale, jitter_exceeded, drift_warning, 2'b00, epoch_done, causality_err}, 64'd0);

    for (int k = 0; k < 11; k++) begin
      if (vt[k].rst) do_reset();
      epoch(vt[k].m, vt[k].t0, vt[k].t1, vt[k].t2, vt[k].t3, lat);
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'(vt[k].lat));
      chk($sformatf("v%0d_aligned", k), aligned_time, vt[k].at);
      chk($sformatf("v%0d_valid", k), {63'd0, time_valid}, 64'd1);
      chk($sformatf("v%0d_stale", k), {60'd0, src_stale}, {60'd0, vt[k].stale});
      chk($sformatf("v%0d_jitter", k), {60'd0, jitter_exceeded}, {60'd0, vt[k].jit});
      chk($sformatf("v%0d_drift", k), {60'd0, drift_warning}, {60'd0, vt[k].drift});
      chk($sformatf("v%0d_causal", k), {63'd0, causality_err}, 64'd0);
    end

    // Single-cycle epoch_done and free-running increment after load.
    do_reset();
    epoch(4'hF, 64'd1000, 64'd1005, 64'd990, 64'd1000, lat);
    chk("h1_latency", 64'(lat), 64'd3);
    chk("h1_aligned", aligned_time, 64'd1000);
    @(negedge clk);
    chk("h1_done_pulse", {63'd0, epoch_done}, 64'd0);
    chk("h1_incr", aligned_time, 64'd1001);

    // Backwards reference: aligned time keeps ticking, causality flags, clear drops it.
    n = 0;
    while (aligned_time < 64'd1010 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("h2_reach_1010", aligned_time, 64'd1010);
    a0 = aligned_time;
    epoch(4'hF, 64'd500, 64'd500, 64'd500, 64'd500, lat);
    chk("h2_latency", 64'(lat), 64'd3);
    chk("h2_aligned_hold", aligned_time, a0 + 64'd3);
    chk("h2_causal_set", {63'd0, causality_err}, 64'd1);
    chk("h2_other_flags", {56'd0, jitter_exceeded, drift_warning}, 64'd0);
    @(negedge clk);
    chk("h2_incr", aligned_time, a0 + 64'd4);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("h2_causal_clear", {63'd0, causality_err}, 64'd0);

    // Reset mid-COLLECT with sources 0 and 1 captured.
    @(negedge clk);
    ts_valid = 4'b0011;
    ts = {64'd5000, 64'd5000, 64'd5000, 64'd5000};
    @(negedge clk);
    ts_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("h3_rst_aligned", aligned_time, 64'd0);
    chk("h3_rst_valid", {63'd0, time_valid}, 64'd0);
    chk("h3_rst_flags", {48'd0, src_stale, jitter_exceeded, drift_warning, 2'b00, epoch_done, causality_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ts_valid = 4'b1100;
    ts = {64'd6000, 64'd6000, 64'd0, 64'd0};
    @(negedge clk);
    ts_valid = '0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | epoch_done;
    end
    chk("h3_needs_fresh", {63'd0, seen}, 64'd0);
    epoch(4'b0011, 64'd7000, 64'd7000, 64'd6000, 64'd6000, lat);
    chk("h3_latency", 64'(lat), 64'd3);
    chk("h3_aligned", aligned_time, 64'd7000);
    chk("h3_stale", {60'd0, src_stale}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
